// File: rtl/recog_pkg.sv
// Shared types and constants for the handwriting recognition controller.
package recog_pkg;

  localparam int         CANVAS_AW = 10;
  localparam logic [7:0] CHAR_ERR  = 8'h3F;
  localparam int         TMO_W     = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    READ  = 2'd2,
    EMIT  = 2'd3
  } state_e;

endpackage

// File: rtl/canvas_port_arb.sv
// Canvas read-port mux: one owner at a time, the non-owner reads constant zero.
module canvas_port_arb
  import recog_pkg::*;
(
  input  logic                 rec_own_i,
  input  logic [CANVAS_AW-1:0] rec_addr_i,
  input  logic [CANVAS_AW-1:0] disp_addr_i,
  input  logic                 disp_req_i,
  input  logic                 cv_data_i,
  output logic [CANVAS_AW-1:0] cv_addr_o,
  output logic                 rec_data_o,
  output logic                 disp_gnt_o,
  output logic                 disp_data_o
);

  assign cv_addr_o   = rec_own_i ? rec_addr_i : disp_addr_i;
  assign disp_gnt_o  = ~rec_own_i & disp_req_i;
  assign rec_data_o  = rec_own_i & cv_data_i;
  assign disp_data_o = disp_gnt_o & cv_data_i;

endmodule

// File: rtl/recog_ctrl.sv
// Recognition sequencer: arbitrates the canvas port and hands results to the text sink.
// Define RECOG_TIMEOUT_EN to abort a stalled recognition with CHAR_ERR and a sticky error.
module recog_ctrl
  import recog_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trig,
  input  logic                 disp_req,
  input  logic [CANVAS_AW-1:0] disp_addr,
  output logic                 disp_gnt,
  output logic                 disp_data,
  output logic                 rec_start,
  input  logic                 rec_en,
  input  logic [CANVAS_AW-1:0] rec_addr,
  output logic                 rec_data,
  input  logic                 rec_valid,
  input  logic [7:0]           rec_result,
  output logic [CANVAS_AW-1:0] cv_addr,
  input  logic                 cv_data,
  output logic                 char_valid,
  output logic [7:0]           char_out,
  input  logic                 char_ready,
  output logic                 busy,
  output logic                 timeout_err
);

  state_e     state_q, state_d;
  logic       trig_pend_q, trig_pend_d;
  logic [7:0] char_out_q, char_out_d;
  logic       timeout_hit;
  logic       timeout_set;
  logic       rec_own;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      trig_pend_q <= 1'b0;
      char_out_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      trig_pend_q <= trig_pend_d;
      char_out_q  <= char_out_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    trig_pend_d = trig_pend_q;
    char_out_d  = char_out_q;
    timeout_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig || trig_pend_q) begin
          state_d     = START;
          trig_pend_d = 1'b0;
        end
      end
      START: begin
        if (trig) trig_pend_d = 1'b1;
        state_d = READ;
      end
      READ: begin
        if (trig) trig_pend_d = 1'b1;
        // A real result always wins over a timeout landing in the same cycle.
        if (rec_valid) begin
          char_out_d = rec_result;
          state_d    = EMIT;
        end else if (timeout_hit) begin
          char_out_d  = CHAR_ERR;
          timeout_set = 1'b1;
          state_d     = EMIT;
        end
      end
      EMIT: begin
        if (trig) trig_pend_d = 1'b1;
        if (char_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef RECOG_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_err_q;
  logic             unused_ok;

  assign timeout_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == START) begin
      tmo_cnt_d = '0;
    end else if (state_q == READ && !rec_valid && !timeout_hit) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      if (timeout_set) timeout_err_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_q;
  assign unused_ok   = rec_en;
`else
  logic unused_ok;

  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
  // The recognizer paces its own reads; rec_en carries no routing meaning here.
  assign unused_ok   = rec_en ^ timeout_set ^ (TIMEOUT_CYCLES == 0);
`endif

  assign rec_own    = (state_q == START) || (state_q == READ);
  assign rec_start  = (state_q == START);
  assign busy       = (state_q != IDLE);
  assign char_valid = (state_q == EMIT);
  assign char_out   = char_out_q;

  canvas_port_arb u_arb (
    .rec_own_i   (rec_own),
    .rec_addr_i  (rec_addr),
    .disp_addr_i (disp_addr),
    .disp_req_i  (disp_req),
    .cv_data_i   (cv_data),
    .cv_addr_o   (cv_addr),
    .rec_data_o  (rec_data),
    .disp_gnt_o  (disp_gnt),
    .disp_data_o (disp_data)
  );

endmodule

// File: doc/recog_ctrl.md
RECOG_CTRL -- requirements
Module: recog_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 2048: cycles allowed from rec_start to rec_valid.
REQ-002 SHALL have port clk, input, 1: clock; all logic rising-edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port trig, input, 1: one-cycle recognition request, from the debounced button.
REQ-005 SHALL have port disp_req, input, 1: display/draw path requests the canvas read port.
REQ-006 SHALL have port disp_addr, input, 10: display read address, {row[4:0], col[4:0]}.
REQ-007 SHALL have port disp_gnt, output, 1: display owns the canvas port this cycle.
REQ-008 SHALL have port disp_data, output, 1: canvas bit routed to the display.
REQ-009 SHALL have port rec_start, output, 1: one-cycle start pulse to the recognizer.
REQ-010 SHALL have port rec_en, input, 1: recognizer read enable.
REQ-011 SHALL have port rec_addr, input, 10: recognizer read address.
REQ-012 SHALL have port rec_data, output, 1: canvas bit routed to the recognizer.
REQ-013 SHALL have port rec_valid, input, 1: recognizer result strobe.
REQ-014 SHALL have port rec_result, input, 8: recognizer ASCII result.
REQ-015 SHALL have port cv_addr, output, 10: shared canvas read address.
REQ-016 SHALL have port cv_data, input, 1: canvas read bit, combinational from cv_addr.
REQ-017 SHALL have port char_valid, output, 1: char_out is valid (valid/ready handshake).
REQ-018 SHALL have port char_out, output, 8: recognized character.
REQ-019 SHALL have port char_ready, input, 1: text sink accepts char_out.
REQ-020 SHALL have port busy, output, 1: high in any state except IDLE.
REQ-021 SHALL have port timeout_err, output, 1: sticky flag, set on timeout.

Function
REQ-022 SHALL implement FSM states IDLE, START, READ, EMIT.
REQ-023 IDLE -> START when trig=1 or trig_pend=1; trig_pend SHALL be cleared on that transition.
REQ-024 START SHALL assert rec_start for exactly one cycle, clear the timeout counter, and go to READ next cycle.
REQ-025 READ -> EMIT on rec_valid=1; rec_result SHALL be latched into char_out in that cycle.
REQ-026 In EMIT, char_valid=1 and char_out SHALL hold stable until a cycle with char_ready=1; EMIT -> IDLE on that cycle.
REQ-027 Arbiter: in START and READ the recognizer owns the port: cv_addr=rec_addr, disp_gnt=0. In all other states cv_addr=disp_addr and disp_gnt=disp_req.
REQ-028 rec_data=cv_data when the recognizer owns the port, else 0; disp_data=cv_data when disp_gnt=1, else 0.
REQ-029 A trig received in START, READ or EMIT SHALL set trig_pend; further trigs SHALL be absorbed into it (depth 1, no counting).
REQ-030 rec_valid outside READ SHALL be ignored.
REQ-031 Simultaneous trig and char_ready in EMIT: go to IDLE and set trig_pend; START follows one cycle later.
REQ-032 Trigger to rec_start latency SHALL be exactly 1 cycle from IDLE.

Reset
REQ-033 rst SHALL force IDLE and clear trig_pend, timeout counter and timeout_err; char_valid=0, char_out=8'h00, rec_start=0, busy=0.
REQ-034 rst in mid-READ SHALL abort immediately; the next cycle returns port ownership to the display.

Configuration
REQ-035 With RECOG_TIMEOUT_EN defined: a 12-bit counter SHALL increment each READ cycle; at count TIMEOUT_CYCLES-1 without rec_valid go to EMIT with char_out=8'h3F ('?') and set timeout_err.
REQ-036 Without RECOG_TIMEOUT_EN: READ SHALL wait for rec_valid indefinitely, and timeout_err SHALL be tied to 0.

Structure
REQ-037 State encoding enum, CANVAS_AW=10 and CHAR_ERR=8'h3F SHALL live in shared package recog_pkg.
REQ-038 The port mux SHALL be a sub-module canvas_port_arb (owner select, addr/data routing, gnt).

Verification
REQ-039 trig at cycle 10 -> rec_start=1 at cycle 11 only, busy=1 from cycle 11, disp_gnt=0 while disp_req=1.
REQ-040 rec_valid with rec_result=8'h41 -> char_valid=1, char_out=8'h41 held for 5 cycles of char_ready=0, then cleared the cycle after char_ready=1.
REQ-041 trig twice during READ -> exactly one extra rec_start, issued after the first char is accepted.
REQ-042 RECOG_TIMEOUT_EN, TIMEOUT_CYCLES=16, no rec_valid -> char_out=8'h3F and timeout_err=1 after 16 READ cycles.
REQ-043 rst asserted mid-READ -> next cycle state IDLE, disp_gnt=disp_req, cv_addr=disp_addr, char_valid=0.
